// File: rtl/nios_system_descriptor_memory_arbiter.sv
// Two-port round-robin arbiter in front of a single-port descriptor RAM (1-cycle read latency).
// Optional feature: define DESC_ARB_LOCK_EN to add pN_lock inputs for atomic read-modify-write.
module nios_system_descriptor_memory_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   p0_address,
    input  logic [DATA_W/8-1:0] p0_byteenable,
    input  logic                p0_read,
    input  logic                p0_write,
    input  logic [DATA_W-1:0]   p0_writedata,

    input  logic [ADDR_W-1:0]   p1_address,
    input  logic [DATA_W/8-1:0] p1_byteenable,
    input  logic                p1_read,
    input  logic                p1_write,
    input  logic [DATA_W-1:0]   p1_writedata,
`ifdef DESC_ARB_LOCK_EN
    input  logic                p0_lock,
    input  logic                p1_lock,
`endif
    output logic                p0_waitrequest,
    output logic [DATA_W-1:0]   p0_readdata,
    output logic                p0_readdatavalid,

    output logic                p1_waitrequest,
    output logic [DATA_W-1:0]   p1_readdata,
    output logic                p1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_P0   = 2'd1,
        GNT_P1   = 2'd2
    } gnt_e;

    logic req0, req1;
    gnt_e gnt;

    logic last_grant_q, last_grant_d;
    logic rd_pending_q, rd_pending_d;
    logic rd_port_q,    rd_port_d;

    // A write strobe dominates a simultaneous read strobe.
    always_comb begin
        req0 = p0_read | p0_write;
        req1 = p1_read | p1_write;
    end

`ifdef DESC_ARB_LOCK_EN
    typedef enum logic [1:0] {
        LK_FREE = 2'd0,
        LK_P0   = 2'd1,
        LK_P1   = 2'd2
    } lock_e;

    lock_e lock_q, lock_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q <= LK_FREE;
        end else begin
            lock_q <= lock_d;
        end
    end

    // Lock is (re)evaluated on every grant of the owning port; an unlocked transfer releases it.
    always_comb begin
        lock_d = lock_q;
        if (gnt == GNT_P0) begin
            lock_d = p0_lock ? LK_P0 : LK_FREE;
        end else if (gnt == GNT_P1) begin
            lock_d = p1_lock ? LK_P1 : LK_FREE;
        end
    end
`endif

    always_comb begin
        gnt = GNT_NONE;
        if (reset_n) begin
`ifdef DESC_ARB_LOCK_EN
            if (lock_q == LK_P0) begin
                if (req0) gnt = GNT_P0;
            end else if (lock_q == LK_P1) begin
                if (req1) gnt = GNT_P1;
            end else
`endif
            begin
                if (req0 && req1) begin
                    gnt = last_grant_q ? GNT_P0 : GNT_P1;
                end else if (req0) begin
                    gnt = GNT_P0;
                end else if (req1) begin
                    gnt = GNT_P1;
                end
            end
        end
    end

    always_comb begin
        p0_waitrequest = req0 & (gnt != GNT_P0);
        p1_waitrequest = req1 & (gnt != GNT_P1);

        mem_clken      = reset_n;
        mem_chipselect = (gnt != GNT_NONE);
        mem_write      = ((gnt == GNT_P0) & p0_write) | ((gnt == GNT_P1) & p1_write);

        if (gnt == GNT_P1) begin
            mem_address    = p1_address;
            mem_byteenable = p1_byteenable;
            mem_writedata  = p1_writedata;
        end else begin
            mem_address    = p0_address;
            mem_byteenable = p0_byteenable;
            mem_writedata  = p0_writedata;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt == GNT_P0) begin
            last_grant_d = 1'b0;
        end else if (gnt == GNT_P1) begin
            last_grant_d = 1'b1;
        end
        rd_pending_d = (gnt != GNT_NONE) & ~mem_write;
        rd_port_d    = (gnt == GNT_P1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            rd_pending_q <= 1'b0;
            rd_port_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pending_q <= rd_pending_d;
            rd_port_q    <= rd_port_d;
        end
    end

    // RAM output is shared; only the owning port's valid is raised.
    always_comb begin
        p0_readdata      = mem_readdata;
        p1_readdata      = mem_readdata;
        p0_readdatavalid = rd_pending_q & ~rd_port_q;
        p1_readdatavalid = rd_pending_q &  rd_port_q;
    end

endmodule

// File: tb/tb_nios_system_descriptor_memory_arbiter.sv
// Bench for the descriptor memory arbiter: RAM model, per-cycle reference model, directed and random traffic.
module tb_nios_system_descriptor_memory_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic [AW-1:0] p0_address, p1_address;
    logic [BW-1:0] p0_byteenable, p1_byteenable;
    logic          p0_read, p0_write, p1_read, p1_write;
    logic [DW-1:0] p0_writedata, p1_writedata;
    logic          p0_waitrequest, p1_waitrequest;
    logic [DW-1:0] p0_readdata, p1_readdata;
    logic          p0_readdatavalid, p1_readdatavalid;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;
    logic [DW-1:0] mem_writedata;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_readdata;
`ifdef DESC_ARB_LOCK_EN
    logic          p0_lock, p1_lock;
`endif

    always #5 clk = ~clk;

    nios_system_descriptor_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(p0_read),
        .p0_write(p0_write), .p0_writedata(p0_writedata),
        .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(p1_read),
        .p1_write(p1_write), .p1_writedata(p1_writedata),
`ifdef DESC_ARB_LOCK_EN
        .p0_lock(p0_lock), .p1_lock(p1_lock),
`endif
        .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
        .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata), .p1_readdatavalid(p1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'h9E37_79B9 * (i + 1);
    endfunction

    // Synchronous RAM: registered address, unregistered output, byte-lane writes.
    logic [DW-1:0] ram [0:DEPTH-1];
    logic [DW-1:0] ram_q = '0;
    bit ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < BW; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end
    assign mem_readdata = ram_q;

    int unsigned checks = 0;
    int unsigned passes = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model state: memory image, who was served last, pending read, lock owner.
    logic [DW-1:0] exp_mem [0:DEPTH-1];
    bit            m_init = 1'b0;
    int            m_last = 1;
    bit            m_pend = 1'b0;
    int            m_pport = 0;
    logic [DW-1:0] m_pdata = '0;
    int            m_lock = -1;
    int            g_seen = -1;
    int            stall0 = 0, stall1 = 0;
    bit            st0 = 1'b0, st1 = 1'b0;

    always @(negedge clk) begin : model_check
        logic r0, r1, w0, w1, l0, l1, gw;
        int g, lk;
        logic [AW-1:0] ga;
        logic [BW-1:0] gbe;
        logic [DW-1:0] gd;
        if (!m_init) begin
            for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_val(i);
            m_init = 1'b1;
        end
        r0 = p0_read | p0_write;
        r1 = p1_read | p1_write;
        w0 = p0_write;
        w1 = p1_write;
        l0 = 1'b0;
        l1 = 1'b0;
`ifdef DESC_ARB_LOCK_EN
        l0 = p0_lock;
        l1 = p1_lock;
`endif
        if (!reset_n) begin
            chk("rst_wait0", p0_waitrequest, r0);
            chk("rst_wait1", p1_waitrequest, r1);
            chk("rst_cs", mem_chipselect, 0);
            chk("rst_write", mem_write, 0);
            chk("rst_clken", mem_clken, 0);
            chk("rst_rdv0", p0_readdatavalid, 0);
            chk("rst_rdv1", p1_readdatavalid, 0);
            m_last = 1; m_pend = 1'b0; m_lock = -1; g_seen = -1;
            stall0 = 0; stall1 = 0; st0 = r0; st1 = r1;
        end else begin
            g = -1;
            lk = m_lock;
            if (lk >= 0) begin
                if ((lk == 0 && r0) || (lk == 1 && r1)) g = lk;
            end else if (r0 && r1) g = 1 - m_last;
            else if (r0) g = 0;
            else if (r1) g = 1;
            gw = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;

            chk("rdv0", p0_readdatavalid, m_pend && m_pport == 0);
            chk("rdv1", p1_readdatavalid, m_pend && m_pport == 1);
            if (m_pend) begin
                chk("rdata0", p0_readdata, m_pdata);
                chk("rdata1", p1_readdata, m_pdata);
            end
            chk("wait0", p0_waitrequest, r0 && g != 0);
            chk("wait1", p1_waitrequest, r1 && g != 1);
            chk("cs", mem_chipselect, g >= 0);
            chk("mwrite", mem_write, gw);
            chk("clken", mem_clken, 1);
            if (g >= 0) begin
                ga  = (g == 0) ? p0_address : p1_address;
                gbe = (g == 0) ? p0_byteenable : p1_byteenable;
                gd  = (g == 0) ? p0_writedata : p1_writedata;
                chk("maddr", mem_address, ga);
                if (gw) begin
                    chk("mbe", mem_byteenable, gbe);
                    chk("mwdata", mem_writedata, gd);
                    for (int b = 0; b < BW; b++)
                        if (gbe[b]) exp_mem[ga][8*b +: 8] = gd[8*b +: 8];
                end else begin
                    m_pdata = exp_mem[ga];
                end
                m_last = g;
                m_lock = ((g == 0) ? l0 : l1) ? g : -1;
            end
            m_pend = (g >= 0) && !gw;
            m_pport = g;

            if (lk >= 0) begin
                stall0 = 0; stall1 = 0;
            end else begin
                stall0 = (r0 && g != 0) ? stall0 + 1 : 0;
                stall1 = (r1 && g != 1) ? stall1 + 1 : 0;
                if (r0) chk("starve0", stall0 <= 1, 1);
                if (r1) chk("starve1", stall1 <= 1, 1);
            end
            g_seen = g;
            st0 = r0 && g != 0;
            st1 = r1 && g != 1;
        end
    end

    task automatic idle();
        p0_read = 0; p0_write = 0; p0_address = '0; p0_byteenable = '0; p0_writedata = '0;
        p1_read = 0; p1_write = 0; p1_address = '0; p1_byteenable = '0; p1_writedata = '0;
`ifdef DESC_ARB_LOCK_EN
        p0_lock = 0; p1_lock = 0;
`endif
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic look();
        @(negedge clk); #1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int sel;
        idle();
        p0_read = 1;
        reset_n = 0;
        repeat (2) look();
        chk("lit_rst_cs", mem_chipselect, 0);
        chk("lit_rst_clken", mem_clken, 0);
        chk("lit_rst_wait0", p0_waitrequest, 1);
        chk("lit_rst_rdv0", p0_readdatavalid, 0);
        idle();
        cyc();
        reset_n = 1;

        // Write then read-back from the other port.
        p0_write = 1; p0_address = 10'h005; p0_writedata = 32'hDEADBEEF; p0_byteenable = 4'hF;
        look();
        chk("lit31_mwrite", mem_write, 1);
        chk("lit31_maddr", mem_address, 10'h005);
        chk("lit31_wait0", p0_waitrequest, 0);
        cyc();
        idle(); p1_read = 1; p1_address = 10'h005;
        look();
        chk("lit31_gnt", g_seen, 1);
        cyc();
        idle();
        look();
        chk("lit31_rdv1", p1_readdatavalid, 1);
        chk("lit31_rdata1", p1_readdata, 32'hDEADBEEF);
        chk("lit31_rdv0", p0_readdatavalid, 0);
        cyc();

        // Continuous contention: grants must alternate starting with port 0.
        for (int i = 0; i < 6; i++) begin
            idle();
            p0_read = 1; p0_address = 10'(i);
            p1_read = 1; p1_address = 10'(8 + i);
            look();
            chk("lit32_gnt", g_seen, i % 2);
            chk("lit32_wait0", p0_waitrequest, i % 2);
            chk("lit32_wait1", p1_waitrequest, 1 - (i % 2));
            cyc();
        end

        // Partial byte-lane write.
        idle(); p0_write = 1; p0_address = 10'h020; p0_writedata = 32'h11223344; p0_byteenable = 4'hF;
        look(); cyc();
        idle(); p1_write = 1; p1_address = 10'h020; p1_writedata = 32'h0000AB00; p1_byteenable = 4'h2;
        look(); cyc();
        idle(); p0_read = 1; p0_address = 10'h020;
        look(); cyc();
        idle();
        look();
        chk("lit33_rdv0", p0_readdatavalid, 1);
        chk("lit33_rdata0", p0_readdata, 32'h1122AB44);
        cyc();

        // Reset pulse with a read in flight.
        idle(); p0_read = 1; p0_address = 10'h003;
        look(); cyc();
        #1 reset_n = 0;
        look();
        chk("lit34_cs", mem_chipselect, 0);
        chk("lit34_rdv0", p0_readdatavalid, 0);
        idle();
        #2 reset_n = 1;
        cyc();
        look();
        chk("lit34_rdv0_after", p0_readdatavalid, 0);
        cyc();

`ifdef DESC_ARB_LOCK_EN
        // Locked read-modify-write on port 0 while port 1 keeps requesting.
        idle(); p1_read = 1; p1_address = 10'h011;
        look(); cyc();
        p0_read = 1; p0_lock = 1; p0_address = 10'h010;
        look();
        chk("lit35_gnt_rd", g_seen, 0);
        chk("lit35_wait1_a", p1_waitrequest, 1);
        cyc();
        p0_read = 0; p0_lock = 0;
        look();
        chk("lit35_wait1_b", p1_waitrequest, 1);
        chk("lit35_cs_b", mem_chipselect, 0);
        cyc();
        p0_write = 1; p0_address = 10'h010; p0_writedata = 32'hCAFE0010; p0_byteenable = 4'hF;
        look();
        chk("lit35_wait1_c", p1_waitrequest, 1);
        chk("lit35_mwrite", mem_write, 1);
        cyc();
        p0_write = 0;
        look();
        chk("lit35_wait1_d", p1_waitrequest, 0);
        chk("lit35_gnt_p1", g_seen, 1);
        cyc();
`endif

        // Random traffic; a stalled requester holds its request unchanged.
        idle();
        for (int n = 0; n < 1500; n++) begin
            if (!st0) begin
                sel = $urandom_range(0, 3);
                p0_read  = (sel == 1 || sel == 3);
                p0_write = (sel == 2 || sel == 3);
                p0_address = 10'($urandom_range(0, 15));
                p0_byteenable = 4'($urandom);
                p0_writedata = $urandom;
`ifdef DESC_ARB_LOCK_EN
                p0_lock = ($urandom_range(0, 3) == 0);
`endif
            end
            if (!st1) begin
                sel = $urandom_range(0, 3);
                p1_read  = (sel == 1 || sel == 3);
                p1_write = (sel == 2 || sel == 3);
                p1_address = 10'($urandom_range(0, 15));
                p1_byteenable = 4'($urandom);
                p1_writedata = $urandom;
`ifdef DESC_ARB_LOCK_EN
                p1_lock = ($urandom_range(0, 3) == 0);
`endif
            end
            look();
            cyc();
        end
        idle();
        look(); cyc();
        look();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/nios_system_descriptor_memory_arbiter.md
NIOS_SYSTEM_DESCRIPTOR_MEMORY_ARBITER -- requirements
Module: nios_system_descriptor_memory_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, shall set the word address width of both requester ports and the memory port.
REQ-002 Parameter DATA_W, default 32, shall set the data width; byteenable width shall be DATA_W/8.
REQ-003 clk  input  1  single clock for all logic; rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 pN_address (N=0,1)  input  ADDR_W  requester word address.
REQ-006 pN_byteenable  input  DATA_W/8  write byte lanes.
REQ-007 pN_read / pN_write  input  1 each  Avalon-MM read and write request strobes.
REQ-008 pN_writedata  input  DATA_W  write data.
REQ-009 pN_waitrequest  output  1  request not accepted this cycle.
REQ-010 pN_readdata  output  DATA_W  read data; qualified by pN_readdatavalid.
REQ-011 pN_readdatavalid  output  1  read data valid, one pulse per accepted read.
REQ-012 mem_address, mem_byteenable, mem_writedata  output  ADDR_W, DATA_W/8, DATA_W  to the descriptor RAM.
REQ-013 mem_chipselect, mem_write, mem_clken  output  1 each  RAM controls.
REQ-014 mem_readdata  input  DATA_W  RAM output: unregistered, valid one cycle after the address is accepted.

Function
REQ-015 pN_request shall be pN_read | pN_write; if both strobes are high, the access shall be a write and the read shall be ignored.
REQ-016 Arbitration shall be combinational within the cycle; exactly one port or none shall be granted per cycle.
REQ-017 Single requester: that port shall be granted. Both requesting: the port other than last_grant shall be granted (round robin).
REQ-018 last_grant register: reset value 1, so port 0 wins the first contention; updated only on a grant.
REQ-019 pN_waitrequest shall equal pN_request & ~grantN; idle ports shall see waitrequest 0.
REQ-020 On grant: mem_chipselect=1, mem_write=granted write, address/byteenable/writedata muxed from the granted port; with no grant: mem_chipselect=0, mem_write=0.
REQ-021 Writes shall complete in the grant cycle with no response.
REQ-022 Granted read: a registered rd_pending flag and port id shall be set; next cycle that port's readdatavalid=1, with pN_readdata=mem_readdata on both ports.
REQ-023 Back-to-back reads, from either port, shall sustain one read per cycle; read latency shall be fixed at 1 cycle.
REQ-024 mem_clken shall be 1 whenever reset_n is high.
REQ-025 No data hazard logic: a write followed by a read of the same address in the next cycle shall return the new data per RAM behaviour.
REQ-026 A requester shall wait no more than one grant to the other port (no starvation).

Reset
REQ-027 While reset_n=0: last_grant=1, rd_pending=0, both pN_readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0; pN_waitrequest=pN_request.
REQ-028 Reset asserted with a read in flight shall discard that read; no readdatavalid shall appear after reset release.

Configuration
REQ-029 Macro DESC_ARB_LOCK_EN defined: add input pN_lock (1 bit); a grant with pN_lock=1 shall hold the grant on port N, blocking the other port, until port N completes a transfer with pN_lock=0. This makes descriptor read-modify-write atomic.
REQ-030 DESC_ARB_LOCK_EN undefined: no pN_lock ports and pure round robin per REQ-017.

Verification
REQ-031 After reset, p0 write addr 0x005 data 0xDEADBEEF be 0xF, then p1 read 0x005 -> p1_readdatavalid one cycle later with 0xDEADBEEF; p0_readdatavalid stays 0.
REQ-032 p0 and p1 both read continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each waitrequest high on alternate cycles.
REQ-033 p1 write be 0x2 data 0x0000AB00 to a word holding 0x11223344 -> subsequent read returns 0x1122AB44.
REQ-034 reset_n pulsed low in the cycle after a p0 read is granted -> no p0_readdatavalid; mem_chipselect=0 during reset.
REQ-035 DESC_ARB_LOCK_EN: p0 locked read then unlocked write of 0x010 with p1 requesting throughout -> p1 waitrequest=1 until the p0 write completes, then p1 is granted.
